eve_gene_scheduler: RTL
=======================

EVE_GENE_SCHEDULER -- requirements
Module: eve_gene_scheduler

Interface
REQ-001 Parameter NUM_PE, default 8, SHALL set the number of crossover PEs served (2..16).
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the gene-pair buffer depth (power of 2, >=2).
REQ-003 Parameter GENE_W, default 64, SHALL set the width of one parent gene word.
REQ-004 input_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  upstream gene pair is valid.
REQ-007 in_ready  out  1  scheduler can accept a pair this cycle.
REQ-008 in_last  in  1  pair is the final gene of the current genome.
REQ-009 parent1_in / parent2_in  in  GENE_W each  parent A / parent B gene.
REQ-010 pe_busy  in  NUM_PE  per-PE busy flag, bit i = PE i.
REQ-011 pe_wr_en  out  NUM_PE  one-hot per-PE write strobe.
REQ-012 parent1_out / parent2_out  out  GENE_W each  gene pair broadcast to all PEs.
REQ-013 genome_done  out  1  single-cycle pulse when a genome is fully consumed.

Function
REQ-014 Buffer SHALL be a FIFO of FIFO_DEPTH entries {last, parent1, parent2}; push when in_valid && in_ready.
REQ-015 in_ready SHALL equal !full, combinationally from registered occupancy; no push when full, even if a pop occurs the same cycle.
REQ-016 FSM states: IDLE, DISPATCH, DRAIN, DONE.
REQ-017 IDLE -> DISPATCH when FIFO non-empty.
REQ-018 In DISPATCH with FIFO non-empty, PE selection SHALL search round-robin from pointer rr for the first PE with pe_busy=0 and not written in the previous cycle.
REQ-019 On selection, next cycle pe_wr_en SHALL be one-hot for exactly one cycle, parent outputs SHALL carry the popped entry, and rr SHALL become (selected+1) mod NUM_PE.
REQ-020 If no PE is eligible, SHALL stall: no pop, pe_wr_en=0, rr unchanged.
REQ-021 Latency: a pair pushed into an empty FIFO while in DISPATCH at cycle N SHALL appear on pe_wr_en at cycle N+2 at the earliest (one cycle FIFO, one cycle output register).
REQ-022 Dispatching an entry with last=1 SHALL move FSM to DRAIN; no further pops until IDLE re-entered.
REQ-023 DRAIN -> DONE when pe_busy==0 and no pe_wr_en is active.
REQ-024 DONE SHALL assert genome_done for one cycle, reset rr to 0, return to IDLE.
REQ-025 Pushes SHALL continue to be accepted in DRAIN/DONE (next genome prefetch).
REQ-026 parent1_out/parent2_out SHALL hold their last value when pe_wr_en=0.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.

Reset
REQ-028 reset low SHALL immediately clear: FSM=IDLE, FIFO empty, rr=0, pe_wr_en=0, genome_done=0, parent outputs=0, in_ready=1 once FIFO empty.
REQ-029 Reset mid-genome SHALL discard all buffered pairs; no genome_done is generated for the aborted genome.

Configuration
REQ-030 Macro EVE_SCHED_STATS_EN defined: extra output gene_count (16 bits) SHALL count pe_wr_en pulses in the current genome, cleared on reset and on the cycle after genome_done, saturating at 16'hFFFF.
REQ-031 Macro undefined: gene_count port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-032 Push 6 node pairs (e.g. A=64'hC82000F722222222, B=64'hC92000F611331133), pe_busy=0, last on 6th -> pe_wr_en one-hot 0x01,0x02,..,0x20 in order, data matches, genome_done one cycle after drain.
REQ-033 pe_busy=8'hFF for 10 cycles with 4 pairs pushed -> in_ready=0 after 4th push, no pe_wr_en; release bit 3 -> first write on PE3, rr=4.
REQ-034 pe_busy=8'b0000_0101 static, 3 pairs -> writes skip PE0/PE2, land on PE1, PE3, PE4.
REQ-035 Last pair dispatched while PE5 busy -> genome_done held off until pe_busy==0, then exactly one pulse; next genome's pairs pushed in DRAIN are dispatched starting at PE0.
REQ-036 Assert reset with 3 pairs buffered mid-genome -> outputs cleared immediately, in_ready=1, no genome_done, subsequent genome dispatches from PE0.
REQ-037 With EVE_SCHED_STATS_EN, 11-gene genome -> gene_count=11 at genome_done, 0 next cycle.

Source files
------------

// File: rtl/eve_gene_scheduler.sv
// Gene-pair scheduler: buffers parent gene pairs and hands them round-robin to idle crossover PEs.
// Optional macro EVE_SCHED_STATS_EN adds a per-genome gene_count output.
module eve_gene_scheduler #(
  parameter int NUM_PE     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int GENE_W     = 64
) (
  input  logic              input_clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [GENE_W-1:0] parent1_in,
  input  logic [GENE_W-1:0] parent2_in,
  input  logic [NUM_PE-1:0] pe_busy,
  output logic [NUM_PE-1:0] pe_wr_en,
  output logic [GENE_W-1:0] parent1_out,
  output logic [GENE_W-1:0] parent2_out,
  output logic              genome_done
`ifdef EVE_SCHED_STATS_EN
  ,
  output logic [15:0]       gene_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(NUM_PE);

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [RW-1:0]     rr_q, rr_d;
  logic [NUM_PE-1:0] peWrEn_q, peWrEn_d;
  logic [GENE_W-1:0] parent1_q, parent1_d, parent2_q, parent2_d;

  logic [GENE_W-1:0] memP1 [FIFO_DEPTH];
  logic [GENE_W-1:0] memP2 [FIFO_DEPTH];
  logic              memLast [FIFO_DEPTH];

  logic              empty, full, push, pop;
  logic              found;
  logic [RW-1:0]     sel, cand;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign in_ready = !full;
  assign push     = in_valid && !full;

  function automatic logic [RW-1:0] wrapIdx(input logic [RW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_PE) s = s - NUM_PE;
    return RW'(s);
  endfunction

  always_ff @(posedge input_clk) begin
    if (push) begin
      memP1[wrPtr_q]   <= parent1_in;
      memP2[wrPtr_q]   <= parent2_in;
      memLast[wrPtr_q] <= in_last;
    end
  end

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) wrPtr_d = wrPtr_q + AW'(1);
    if (pop)  rdPtr_d = rdPtr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A PE written last cycle may not have raised busy yet, so it is skipped.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int off = 0; off < NUM_PE; off++) begin
      cand = wrapIdx(rr_q, off);
      if (!found && !pe_busy[cand] && !peWrEn_q[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    peWrEn_d  = '0;
    parent1_d = parent1_q;
    parent2_d = parent2_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) state_d = DISPATCH;
      end
      DISPATCH: begin
        if (!empty && found) begin
          pop       = 1'b1;
          peWrEn_d  = {{(NUM_PE-1){1'b0}}, 1'b1} << sel;
          parent1_d = memP1[rdPtr_q];
          parent2_d = memP2[rdPtr_q];
          rr_d      = (sel == RW'(NUM_PE - 1)) ? '0 : sel + RW'(1);
          if (memLast[rdPtr_q]) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pe_busy == '0 && peWrEn_q == '0) state_d = DONE;
      end
      DONE: begin
        rr_d    = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      rr_q      <= '0;
      peWrEn_q  <= '0;
      parent1_q <= '0;
      parent2_q <= '0;
    end else begin
      state_q   <= state_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      rr_q      <= rr_d;
      peWrEn_q  <= peWrEn_d;
      parent1_q <= parent1_d;
      parent2_q <= parent2_d;
    end
  end

  assign pe_wr_en    = peWrEn_q;
  assign parent1_out = parent1_q;
  assign parent2_out = parent2_q;
  assign genome_done = (state_q == DONE);

`ifdef EVE_SCHED_STATS_EN
  // Counts dispatches of the running genome; cleared once its done pulse has been shown.
  logic [15:0] geneCount_q, geneCount_d;

  always_comb begin
    geneCount_d = geneCount_q;
    if (state_q == DONE)
      geneCount_d = '0;
    else if (peWrEn_d != '0 && geneCount_q != 16'hFFFF)
      geneCount_d = geneCount_q + 16'd1;
  end

  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) geneCount_q <= '0;
    else        geneCount_q <= geneCount_d;
  end

  assign gene_count = geneCount_q;
`endif

endmodule
